// File: rtl/core_hazard_pkg.sv
// Shared encodings for the hazard unit: forwarding selects, FSM states,
// pipeline-register bit positions and the bubble-counter width.
package core_hazard_pkg;

  // Operand source selects driven onto fwd_src1_o / fwd_src2_o
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Bit positions inside enb_o / kill_o
  localparam int STG_IF_DEC  = 0;
  localparam int STG_DEC_EXE = 1;
  localparam int STG_EXE_MEM = 2;
  localparam int STG_MEM_WB  = 3;

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    FLUSH    = 2'd2
  } hz_state_e;

endpackage

// File: rtl/core_hazard_if.sv
// Bundle of pipeline status inputs and hazard-control outputs.
// master: pipeline side (drives status, receives controls).
// slave : hazard unit side.
interface core_hazard_if #(
  parameter int REG_AW   = 5,
  parameter int N_STAGES = 4
);

  logic [REG_AW-1:0]   dec_rs1_i, dec_rs2_i;
  logic [REG_AW-1:0]   exe_rs1_i, exe_rs2_i, exe_rd_i;
  logic                exe_we_i, exe_load_i, exe_jump_i, exe_brnch_i, brnch_tkn_i;
  logic [REG_AW-1:0]   mem_rd_i, wb_rd_i;
  logic                mem_we_i, wb_we_i;
  logic                icache_stall_i, dcache_stall_i;

  logic [N_STAGES-1:0] enb_o, kill_o;
  logic                pc_stop_o, nop_gen_o, pc_redirect_o;
  logic [1:0]          fwd_src1_o, fwd_src2_o;

  modport master (
    output dec_rs1_i, dec_rs2_i, exe_rs1_i, exe_rs2_i, exe_rd_i,
           exe_we_i, exe_load_i, exe_jump_i, exe_brnch_i, brnch_tkn_i,
           mem_rd_i, wb_rd_i, mem_we_i, wb_we_i, icache_stall_i, dcache_stall_i,
    input  enb_o, kill_o, pc_stop_o, nop_gen_o, pc_redirect_o, fwd_src1_o, fwd_src2_o
  );

  modport slave (
    input  dec_rs1_i, dec_rs2_i, exe_rs1_i, exe_rs2_i, exe_rd_i,
           exe_we_i, exe_load_i, exe_jump_i, exe_brnch_i, brnch_tkn_i,
           mem_rd_i, wb_rd_i, mem_we_i, wb_we_i, icache_stall_i, dcache_stall_i,
    output enb_o, kill_o, pc_stop_o, nop_gen_o, pc_redirect_o, fwd_src1_o, fwd_src2_o
  );

endinterface

// File: rtl/core_hazard_fwd.sv
// Forwarding comparator for one EXE source operand.
// The younger MEM result wins over WB; x0 is never forwarded.
module core_hazard_fwd
  import core_hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_we_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_we_i,
  output logic [1:0]        src_o
);

  // Priority select: MEM, then WB, else register file
  always_comb begin
    src_o = FWD_RF;
    if (mem_we_i && (rs_i != '0) && (mem_rd_i == rs_i)) begin
      src_o = FWD_MEM;
    end else if (wb_we_i && (rs_i != '0) && (wb_rd_i == rs_i)) begin
      src_o = FWD_WB;
    end
  end

endmodule

// File: rtl/core_hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use bubbles, branch/jump
// flush and cache-stall freezing. Optional saturating performance counters
// are built when CORE_HAZARD_PERF_CNT_EN is defined.
module core_hazard_unit
  import core_hazard_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int N_STAGES  = 4,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 1
) (
  input  logic          clk,
  input  logic          rst,
  core_hazard_if.slave  hz
`ifdef CORE_HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]   perf_stall_o,
  output logic [31:0]   perf_flush_o
`endif
);

  hz_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                load_use;
  logic                redirect;
  logic [N_STAGES-1:0] enb_v, kill_v;
  logic                nop_v, redir_v, stop_v;
  logic [REG_AW-1:0]   exe_rs [2];
  logic [1:0]          fwd_raw [2];

  assign load_use = hz.exe_load_i & hz.exe_we_i & (hz.exe_rd_i != '0) &
                    ((hz.exe_rd_i == hz.dec_rs1_i) | (hz.exe_rd_i == hz.dec_rs2_i));
  assign redirect = hz.exe_jump_i | (hz.exe_brnch_i & hz.brnch_tkn_i);

  assign exe_rs[0] = hz.exe_rs1_i;
  assign exe_rs[1] = hz.exe_rs2_i;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    core_hazard_fwd #(.REG_AW(REG_AW)) u_fwd (
      .rs_i     (exe_rs[gi]),
      .mem_rd_i (hz.mem_rd_i),
      .mem_we_i (hz.mem_we_i),
      .wb_rd_i  (hz.wb_rd_i),
      .wb_we_i  (hz.wb_we_i),
      .src_o    (fwd_raw[gi])
    );
  end

  assign hz.fwd_src1_o = rst ? FWD_RF : fwd_raw[0];
  assign hz.fwd_src2_o = rst ? FWD_RF : fwd_raw[1];

  // Pipeline control outputs from current state and live hazards
  always_comb begin
    enb_v   = '1;
    kill_v  = '0;
    nop_v   = 1'b0;
    redir_v = 1'b0;
    if (rst) begin
      enb_v  = '0;
      kill_v = '1;
    end else if (hz.dcache_stall_i) begin
      // Whole pipe frozen; a redirect is re-presented once the stall clears
      enb_v = '0;
    end else begin
      if (redirect) begin
        redir_v                 = 1'b1;
        kill_v[STG_IF_DEC]      = 1'b1;
        kill_v[STG_DEC_EXE]     = 1'b1;
      end else if ((state_q == RUN && load_use) || state_q == LD_STALL) begin
        enb_v[STG_IF_DEC] = 1'b0;
        nop_v             = 1'b1;
      end
      if (hz.icache_stall_i) begin
        enb_v[STG_IF_DEC] = 1'b0;
        nop_v             = 1'b1;
      end
    end
    stop_v = ~&enb_v;
  end

  assign hz.enb_o         = enb_v;
  assign hz.kill_o        = kill_v;
  assign hz.nop_gen_o     = nop_v;
  assign hz.pc_redirect_o = redir_v;
  assign hz.pc_stop_o     = stop_v;

  // Next-state: redirect beats load-use, dcache stall freezes everything
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (hz.dcache_stall_i) begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end else if (redirect) begin
      state_d = FLUSH;
      cnt_d   = CNT_W'(FLUSH_CYC - 1);
    end else begin
      case (state_q)
        RUN: begin
          if (load_use && LOAD_LAT > 1) begin
            state_d = LD_STALL;
            cnt_d   = CNT_W'(LOAD_LAT - 1);
          end
        end
        LD_STALL: begin
          // Counter value equals remaining bubbles including this one
          if (cnt_q <= CNT_W'(1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        FLUSH: begin
          if (cnt_q == '0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM state and bubble counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef CORE_HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Saturating event counters
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (stop_v && perf_stall_q != '1) perf_stall_d = perf_stall_q + 32'd1;
    if (redir_v && perf_flush_q != '1) perf_flush_d = perf_flush_q + 32'd1;
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_o = perf_stall_q;
  assign perf_flush_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_core_hazard_unit.sv
// Directed bench for core_hazard_unit (LOAD_LAT=3, FLUSH_CYC=2).
module tb_core_hazard_unit;
  import core_hazard_pkg::*;

  localparam int REG_AW    = 5;
  localparam int N_STAGES  = 4;
  localparam int LOAD_LAT  = 3;
  localparam int FLUSH_CYC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  core_hazard_if #(.REG_AW(REG_AW), .N_STAGES(N_STAGES)) hz_if ();

`ifdef CORE_HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall, perf_flush;
`endif

  core_hazard_unit #(
    .REG_AW(REG_AW), .N_STAGES(N_STAGES), .LOAD_LAT(LOAD_LAT), .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz_if)
`ifdef CORE_HAZARD_PERF_CNT_EN
    ,
    .perf_stall_o (perf_stall),
    .perf_flush_o (perf_flush)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, got);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] enb, input logic [3:0] kill,
                         input logic nop, input logic redir, input logic stop);
    check({tag, ".enb"},   32'(hz_if.enb_o),         32'(enb));
    check({tag, ".kill"},  32'(hz_if.kill_o),        32'(kill));
    check({tag, ".nop"},   32'(hz_if.nop_gen_o),     32'(nop));
    check({tag, ".redir"}, 32'(hz_if.pc_redirect_o), 32'(redir));
    check({tag, ".stop"},  32'(hz_if.pc_stop_o),     32'(stop));
  endtask

  task automatic chk_fsm(input string tag, input hz_state_e st, input int cnt);
    check({tag, ".state"}, 32'(dut.state_q), 32'(st));
    check({tag, ".cnt"},   32'(dut.cnt_q),   32'(cnt));
  endtask

  task automatic clear_in();
    hz_if.dec_rs1_i = '0; hz_if.dec_rs2_i = '0;
    hz_if.exe_rs1_i = '0; hz_if.exe_rs2_i = '0; hz_if.exe_rd_i = '0;
    hz_if.exe_we_i = 1'b0; hz_if.exe_load_i = 1'b0; hz_if.exe_jump_i = 1'b0;
    hz_if.exe_brnch_i = 1'b0; hz_if.brnch_tkn_i = 1'b0;
    hz_if.mem_rd_i = '0; hz_if.wb_rd_i = '0; hz_if.mem_we_i = 1'b0; hz_if.wb_we_i = 1'b0;
    hz_if.icache_stall_i = 1'b0; hz_if.dcache_stall_i = 1'b0;
  endtask

  task automatic set_load_use();
    hz_if.exe_load_i = 1'b1; hz_if.exe_we_i = 1'b1;
    hz_if.exe_rd_i = 5'd7;   hz_if.dec_rs2_i = 5'd7;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Forwarding vectors: mem_we, mem_rd, wb_we, wb_rd, rs1, rs2, exp1, exp2
  typedef struct {
    logic mem_we; logic [4:0] mem_rd; logic wb_we; logic [4:0] wb_rd;
    logic [4:0] rs1; logic [4:0] rs2; logic [1:0] e1; logic [1:0] e2;
  } fwd_vec_t;

  fwd_vec_t fwd_tbl [6] = '{
    '{1'b1, 5'd5, 1'b1, 5'd5, 5'd5, 5'd0, 2'b01, 2'b00},
    '{1'b1, 5'd5, 1'b1, 5'd5, 5'd0, 5'd9, 2'b00, 2'b00},
    '{1'b0, 5'd5, 1'b1, 5'd5, 5'd5, 5'd5, 2'b10, 2'b10},
    '{1'b1, 5'd3, 1'b1, 5'd5, 5'd5, 5'd3, 2'b10, 2'b01},
    '{1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00},
    '{1'b1, 5'd6, 1'b0, 5'd5, 5'd5, 5'd6, 2'b00, 2'b01}
  };

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_in();
    hz_if.mem_we_i = 1'b1; hz_if.mem_rd_i = 5'd5; hz_if.exe_rs1_i = 5'd5;
    rst = 1'b1;
    repeat (2) tick();
    #1;
    chk_out("reset", 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1);
    check("reset.fwd1", 32'(hz_if.fwd_src1_o), 32'(2'b00));
    chk_fsm("reset", RUN, 0);

    rst = 1'b0;
    tick();
    clear_in();
    #1;
    chk_out("idle", 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Forwarding table (combinational, FSM untouched)
    for (int i = 0; i < 6; i++) begin
      hz_if.mem_we_i = fwd_tbl[i].mem_we; hz_if.mem_rd_i = fwd_tbl[i].mem_rd;
      hz_if.wb_we_i  = fwd_tbl[i].wb_we;  hz_if.wb_rd_i  = fwd_tbl[i].wb_rd;
      hz_if.exe_rs1_i = fwd_tbl[i].rs1;   hz_if.exe_rs2_i = fwd_tbl[i].rs2;
      #1;
      check($sformatf("fwd%0d.src1", i), 32'(hz_if.fwd_src1_o), 32'(fwd_tbl[i].e1));
      check($sformatf("fwd%0d.src2", i), 32'(hz_if.fwd_src2_o), 32'(fwd_tbl[i].e2));
    end
    clear_in();

    // Non-hazards: rd=x0, and load without write enable
    hz_if.exe_load_i = 1'b1; hz_if.exe_we_i = 1'b1; hz_if.exe_rd_i = 5'd0;
    #1;
    check("nohaz_x0.enb", 32'(hz_if.enb_o), 32'(4'b1111));
    hz_if.exe_rd_i = 5'd7; hz_if.dec_rs1_i = 5'd7; hz_if.exe_we_i = 1'b0;
    #1;
    check("nohaz_nowe.enb", 32'(hz_if.enb_o), 32'(4'b1111));
    clear_in();

    // Instruction cache stall
    hz_if.icache_stall_i = 1'b1;
    #1;
    chk_out("icache", 4'b1110, 4'b0000, 1'b1, 1'b0, 1'b1);
    clear_in();

    // Load-use: exactly LOAD_LAT bubbles
    set_load_use();
    #1;
    chk_out("lu_b1", 4'b1110, 4'b0000, 1'b1, 1'b0, 1'b1);
    tick(); clear_in(); #1;
    chk_fsm("lu_b2", LD_STALL, 2);
    chk_out("lu_b2", 4'b1110, 4'b0000, 1'b1, 1'b0, 1'b1);
    tick(); #1;
    chk_fsm("lu_b3", LD_STALL, 1);
    chk_out("lu_b3", 4'b1110, 4'b0000, 1'b1, 1'b0, 1'b1);
    tick(); #1;
    chk_fsm("lu_done", RUN, 0);
    chk_out("lu_done", 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Data cache stall for 4 cycles while LD_STALL counter=2
    set_load_use();
    tick(); clear_in(); #1;
    chk_fsm("dc_pre", LD_STALL, 2);
    for (int i = 0; i < 4; i++) begin
      hz_if.dcache_stall_i = 1'b1;
      hz_if.exe_jump_i = (i == 1);
      #1;
      chk_out($sformatf("dc%0d", i), 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
      tick();
    end
    clear_in(); #1;
    chk_fsm("dc_post", LD_STALL, 2);
    chk_out("dc_post", 4'b1110, 4'b0000, 1'b1, 1'b0, 1'b1);
    tick(); #1;
    chk_fsm("dc_post2", LD_STALL, 1);
    tick(); #1;
    chk_fsm("dc_done", RUN, 0);

    // Taken branch during LD_STALL abandons the stall
    set_load_use();
    tick(); clear_in(); #1;
    chk_fsm("br_pre", LD_STALL, 2);
    hz_if.exe_brnch_i = 1'b1; hz_if.brnch_tkn_i = 1'b1;
    #1;
    chk_out("br_tkn", 4'b1111, 4'b0011, 1'b0, 1'b1, 1'b0);
    tick(); clear_in(); set_load_use(); #1;
    chk_fsm("flush1", FLUSH, 1);
    chk_out("flush1_sup", 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
    tick(); #1;
    chk_fsm("flush0", FLUSH, 0);
    chk_out("flush0_sup", 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
    tick(); clear_in(); #1;
    chk_fsm("flush_done", RUN, 0);

    // Not-taken branch: no redirect
    hz_if.exe_brnch_i = 1'b1;
    #1;
    check("br_ntkn.redir", 32'(hz_if.pc_redirect_o), 32'(1'b0));
    clear_in();

    // Jump and load-use together: redirect wins
    set_load_use(); hz_if.exe_jump_i = 1'b1;
    #1;
    chk_out("jmp_lu", 4'b1111, 4'b0011, 1'b0, 1'b1, 1'b0);
    tick(); clear_in(); #1;
    chk_fsm("jmp_flush", FLUSH, 1);

    // Reset pulse mid-flush
    rst = 1'b1;
    #1;
    chk_out("rst_mid", 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1);
    tick(); #1;
    chk_out("rst_hold", 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    tick(); #1;
    chk_fsm("rst_rel", RUN, 0);
    chk_out("rst_rel", 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_hazard_unit.md
CORE_HAZARD_UNIT -- requirements
Module: core_hazard_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter N_STAGES, default 4, number of pipeline registers controlled (minimum 4).
REQ-003 SHALL have parameter LOAD_LAT, default 1, load-use bubble cycles (range 1..7).
REQ-004 SHALL have parameter FLUSH_CYC, default 1, post-redirect load-use suppression cycles (range 1..3).
REQ-005 SHALL have ports: clk in 1, clock; rst in 1, reset, synchronous, active-high.
REQ-006 SHALL have ports: dec_rs1_i, dec_rs2_i in REG_AW, decode sources.
REQ-007 SHALL have ports: exe_rs1_i, exe_rs2_i, exe_rd_i in REG_AW; exe_we_i, exe_load_i, exe_jump_i, exe_brnch_i, brnch_tkn_i in 1.
REQ-008 SHALL have ports: mem_rd_i, wb_rd_i in REG_AW; mem_we_i, wb_we_i in 1.
REQ-009 SHALL have ports: icache_stall_i, dcache_stall_i in 1.
REQ-010 SHALL have outputs: enb_o, kill_o N_STAGES (bit0 IF/DEC, bit1 DEC/EXE, bit2 EXE/MEM, bit3 MEM/WB); pc_stop_o, nop_gen_o, pc_redirect_o 1; fwd_src1_o, fwd_src2_o 2.

Function
REQ-011 fwd_srcN_o SHALL be combinational: 01 (MEM) if mem_we_i and mem_rd_i==exe_rsN_i!=0; else 10 (WB) if wb_we_i and wb_rd_i==exe_rsN_i!=0; else 00 (regfile); MEM has priority.
REQ-012 FSM SHALL have states RUN, LD_STALL, FLUSH, with a 3-bit bubble counter.
REQ-013 Load-use hazard SHALL be exe_load_i & exe_we_i & exe_rd_i!=0 & (exe_rd_i==dec_rs1_i | exe_rd_i==dec_rs2_i).
REQ-014 In RUN on load-use: enb_o[0]=0, nop_gen_o=1, pc_stop_o=1 that cycle; if LOAD_LAT>1 go LD_STALL with counter=LOAD_LAT-1, else stay RUN.
REQ-015 In LD_STALL: same stall outputs; counter decrements per enabled cycle; go RUN when counter reaches 0 (exactly LOAD_LAT bubbles total).
REQ-016 Redirect = exe_jump_i | (exe_brnch_i & brnch_tkn_i): pc_redirect_o=1 and kill_o[1:0]=11 for one cycle; FSM SHALL go FLUSH with counter=FLUSH_CYC-1 from any state.
REQ-017 In FLUSH: load-use detection suppressed; return RUN when counter is 0.
REQ-018 Redirect SHALL take priority over load-use in the same cycle; pending LD_STALL SHALL be abandoned.
REQ-019 dcache_stall_i SHALL force enb_o=all 0, pc_stop_o=1, pc_redirect_o=0, kill_o=0, and freeze FSM state and counter.
REQ-020 icache_stall_i (without dcache stall) SHALL force enb_o[0]=0, nop_gen_o=1, pc_stop_o=1; FSM continues.
REQ-021 pc_stop_o SHALL equal NOT(AND of enb_o) outside reset.
REQ-022 Idle outputs: enb_o all 1, kill_o 0, nop_gen_o 0, pc_redirect_o 0, pc_stop_o 0.

Reset
REQ-023 While rst=1: enb_o=0, kill_o=all 1, pc_stop_o=1, nop_gen_o=0, pc_redirect_o=0, fwd 00; state=RUN, counter=0 on next edge.
REQ-024 Reset asserted mid-stall or mid-flush SHALL abort the sequence; first cycle after release SHALL be RUN.

Configuration
REQ-025 With CORE_HAZARD_PERF_CNT_EN defined: 32-bit outputs perf_stall_o (counts cycles with pc_stop_o=1) and perf_flush_o (counts redirects), saturating, cleared by rst.
REQ-026 Without CORE_HAZARD_PERF_CNT_EN: those ports and counters SHALL not exist; other behaviour identical.

Structure
REQ-027 Package core_hazard_pkg SHALL hold FWD_RF/FWD_MEM/FWD_WB encodings, FSM state enum, and stage bit indices.
REQ-028 Sub-module core_hazard_fwd SHALL implement one forwarding comparator, instantiated per source operand.

Verification
REQ-029 mem_we=1, mem_rd=5, wb_we=1, wb_rd=5, exe_rs1=5 -> fwd_src1_o=01; exe_rs1=0 -> 00.
REQ-030 LOAD_LAT=3, load exe_rd=7, dec_rs2=7 -> enb_o[0]=0, nop_gen_o=1 for exactly 3 cycles, then RUN.
REQ-031 Taken branch during LD_STALL -> pc_redirect_o=1 and kill_o=0011 for one cycle, stall abandoned, FSM goes FLUSH.
REQ-032 dcache_stall_i for 4 cycles during LD_STALL counter=2 -> enb_o=0000 for 4 cycles, counter still 2 afterwards.
REQ-033 rst pulse mid-FLUSH -> kill_o=1111 during reset, RUN and idle outputs on first cycle after release.
